// File: rtl/riscv_muldiv_pkg.sv
// Shared types and helpers for the iterative RV M-extension multiply/divide unit.
package riscv_muldiv_pkg;

  // funct3 encodings of the M-extension ops
  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } t_muldiv_op;

  typedef logic [1:0] t_muldiv_state;

  localparam t_muldiv_state StIdle = 2'd0;
  localparam t_muldiv_state StCalc = 2'd1;
  localparam t_muldiv_state StDone = 2'd2;

  // Number of CALC cycles needed to consume all XLEN operand bits.
  function automatic int unsigned muldiv_iters(input int unsigned xlen, input int unsigned unroll);
    return xlen / unroll;
  endfunction

endpackage

// File: rtl/riscv_muldiv_step.sv
// One combinational shift-add (multiply) or restoring-subtract (divide) iteration.
// Accumulator layout is {hi, lo}: product-high/multiplier or remainder/dividend-quotient.
module riscv_muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              div_mode,
  output logic [2*XLEN-1:0] acc_next,
  output logic              q_bit
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;

  always_comb begin
    hi       = acc[2*XLEN-1:XLEN];
    lo       = acc[XLEN-1:0];
    sum      = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
    rem_sh   = {hi, lo[XLEN-1]};
    diff     = rem_sh - {1'b0, operand};
    q_bit    = 1'b0;
    acc_next = {sum, lo[XLEN-1:1]};
    if (div_mode) begin
      // remainder stays below the divisor, so the borrow bit alone decides the quotient bit
      q_bit    = ~diff[XLEN];
      acc_next = {(q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]), lo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/riscv_xlen_muldiv.sv
// Iterative RV M-extension multiply/divide unit with valid/ready request and response channels.
// Optional build macro RISCV_MULDIV_EARLY_OUT_EN: multiplies finish once remaining multiplier bits are zero.
module riscv_xlen_muldiv
  import riscv_muldiv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_tag,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic [4:0]      resp_tag,
  output logic            busy
);

  localparam int unsigned NITER = muldiv_iters(XLEN, UNROLL);
  localparam int unsigned CNT_W = $clog2(NITER + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(NITER);

  t_muldiv_state     state_q, state_d;
  t_muldiv_op        op_q, op_d;
  logic [4:0]        tag_q, tag_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Request decode
  t_muldiv_op      req_op_e;
  logic            accept;
  logic            in_div, is_rem, rs1_signed, rs2_signed, s1, s2;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] mag1, mag2;

  assign req_op_e = t_muldiv_op'(req_op);
  assign accept   = req_valid & req_ready;

  always_comb begin
    in_div     = req_op[2];
    is_rem     = (req_op_e == OpRem) || (req_op_e == OpRemu);
    rs1_signed = req_op_e inside {OpMulh, OpMulhsu, OpDiv, OpRem};
    rs2_signed = req_op_e inside {OpMulh, OpDiv, OpRem};
    s1         = rs1_signed & req_rs1[XLEN-1];
    s2         = rs2_signed & req_rs2[XLEN-1];
    mag1       = s1 ? -req_rs1 : req_rs1;
    mag2       = s2 ? -req_rs2 : req_rs2;
    div_zero   = in_div && (req_rs2 == '0);
    div_ovf    = ((req_op_e == OpDiv) || (req_op_e == OpRem)) &&
                 (req_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (req_rs2 == '1);
  end

  // Iteration chain, UNROLL steps per clock
  logic [2*XLEN-1:0] acc_chain [UNROLL+1];
  logic [2*XLEN-1:0] step_acc  [UNROLL];
  logic [UNROLL-1:0] step_q;
  logic [2*XLEN-1:0] chain_out;

  assign acc_chain[0] = acc_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    riscv_muldiv_step #(
      .XLEN(XLEN)
    ) u_step (
      .acc      (acc_chain[i]),
      .operand  (opb_q),
      .div_mode (op_q[2]),
      .acc_next (step_acc[i]),
      .q_bit    (step_q[i])
    );
    assign acc_chain[i+1] = {step_acc[i][2*XLEN-1:1], step_acc[i][0] | step_q[i]};
  end

  assign chain_out = acc_chain[UNROLL];

  // Multiply finalisation source and early-out detection
  logic [2*XLEN-1:0] mul_src;
  logic              early_done;

`ifdef RISCV_MULDIV_EARLY_OUT_EN
  localparam int unsigned SHW = $clog2(XLEN) + 1;
  logic [SHW-1:0] rem_amt;

  // Bits still to be consumed after this cycle's steps; they sit at the bottom of lo.
  assign rem_amt    = SHW'((32'(cnt_q) - 32'd1) * UNROLL);
  assign early_done = ~op_q[2] && ((chain_out[XLEN-1:0] << (SHW'(XLEN) - rem_amt)) == '0);
  assign mul_src    = chain_out >> rem_amt;
`else
  assign early_done = 1'b0;
  assign mul_src    = chain_out;
`endif

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   div_src;
  logic [XLEN-1:0]   fin_val;

  always_comb begin
    prod    = neg_q ? -mul_src : mul_src;
    div_src = ((op_q == OpRem) || (op_q == OpRemu)) ? chain_out[2*XLEN-1:XLEN]
                                                    : chain_out[XLEN-1:0];
    if (op_q[2]) begin
      fin_val = neg_q ? -div_src : div_src;
    end else if (op_q == OpMul) begin
      fin_val = prod[XLEN-1:0];
    end else begin
      fin_val = prod[2*XLEN-1:XLEN];
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tag_d    = tag_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          op_d  = req_op_e;
          tag_d = req_tag;
          neg_d = is_rem ? s1 : (s1 ^ s2);
          cnt_d = CNT_INIT;
          if (div_zero) begin
            result_d = is_rem ? req_rs1 : '1;
            state_d  = StDone;
          end else if (div_ovf) begin
            result_d = is_rem ? '0 : req_rs1;
            state_d  = StDone;
          end else begin
            acc_d   = {{XLEN{1'b0}}, (in_div ? mag1 : mag2)};
            opb_d   = in_div ? mag2 : mag1;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d = chain_out;
        cnt_d = cnt_q - CNT_W'(1);
        if ((cnt_q == CNT_W'(1)) || early_done) begin
          result_d = fin_val;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d  = StIdle;
      result_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      tag_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign req_ready   = (state_q == StIdle) && !flush;
  assign resp_valid  = (state_q == StDone);
  assign busy        = (state_q != StIdle);
  assign resp_result = result_q;
  assign resp_tag    = tag_q;

endmodule

// File: tb/tb_riscv_xlen_muldiv.sv
// Directed bench for riscv_xlen_muldiv: 32-bit UNROLL=1 table plus 64-bit UNROLL=4 instance.
module tb_riscv_xlen_muldiv;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

`ifdef RISCV_MULDIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        flush, req_valid, req_ready, resp_valid, resp_ready, busy;
  logic [2:0]  req_op;
  logic [31:0] req_rs1, req_rs2, resp_result;
  logic [4:0]  req_tag, resp_tag;

  logic        flush64, req_valid64, req_ready64, resp_valid64, resp_ready64, busy64;
  logic [2:0]  req_op64;
  logic [63:0] req_rs1_64, req_rs2_64, resp_result64;
  logic [4:0]  req_tag64, resp_tag64;

  riscv_xlen_muldiv #(.XLEN(32), .UNROLL(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_tag     (req_tag),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_tag    (resp_tag),
    .busy        (busy)
  );

  riscv_xlen_muldiv #(.XLEN(64), .UNROLL(4)) dut64 (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush64),
    .req_valid   (req_valid64),
    .req_ready   (req_ready64),
    .req_op      (req_op64),
    .req_rs1     (req_rs1_64),
    .req_rs2     (req_rs2_64),
    .req_tag     (req_tag64),
    .resp_valid  (resp_valid64),
    .resp_ready  (resp_ready64),
    .resp_result (resp_result64),
    .resp_tag    (resp_tag64),
    .busy        (busy64)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Latency counts the accepting edge as edge 1.
  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output logic [31:0] res, output logic [4:0] rtag,
                       output int lat);
    int guard = 0;
    while (!req_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    res  = resp_result;
    rtag = resp_tag;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic run64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tag, output logic [63:0] res, output logic [4:0] rtag,
                       output int lat);
    int guard = 0;
    while (!req_ready64 && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    req_valid64 = 1'b1; req_op64 = op; req_rs1_64 = a; req_rs2_64 = b; req_tag64 = tag;
    @(posedge clk); #1;
    req_valid64 = 1'b0;
    lat = 1;
    while (!resp_valid64 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    res  = resp_result64;
    rtag = resp_tag64;
    resp_ready64 = 1'b1;
    @(posedge clk); #1;
    resp_ready64 = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          lat_eo;
  } vec_t;

  vec_t vecs [17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic [63:0] res64;
    logic [4:0]  rtag;
    int          lat;
    int          n;
    bit          seen, stable_ok;

    vecs[0]  = '{OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 33};
    vecs[1]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 33};
    vecs[2]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33, 3};
    vecs[3]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, 33};
    vecs[4]  = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1};
    vecs[5]  = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1};
    vecs[6]  = '{OP_DIVU,   32'd100,      32'd0,        32'hFFFFFFFF, 1, 1};
    vecs[7]  = '{OP_REMU,   32'd100,      32'd0,        32'd100,      1, 1};
    vecs[8]  = '{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 33};
    vecs[9]  = '{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 33};
    vecs[10] = '{OP_MULH,   32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, 33, 4};
    vecs[11] = '{OP_DIV,    32'd0,        32'd0,        32'hFFFFFFFF, 1, 1};
    vecs[12] = '{OP_REM,    32'd20,       32'hFFFFFFFA, 32'd2,        33, 33};
    vecs[13] = '{OP_DIVU,   32'h80000000, 32'd3,        32'h2AAAAAAA, 33, 33};
    vecs[14] = '{OP_MULHU,  32'h12345678, 32'h00010000, 32'h00001234, 33, 18};
    vecs[15] = '{OP_MUL,    32'd5,        32'd1,        32'd5,        33, 2};
    vecs[16] = '{OP_REMU,   32'd100,      32'd7,        32'd2,        33, 33};

    reset = 1'b1;
    flush = 1'b0; req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
    resp_ready = 1'b0;
    flush64 = 1'b0; req_valid64 = 1'b0; req_op64 = '0; req_rs1_64 = '0; req_rs2_64 = '0;
    req_tag64 = '0; resp_ready64 = 1'b0;

    #12;
    check("reset resp_valid", 64'(resp_valid), 64'd0);
    check("reset resp_result", 64'(resp_result), 64'd0);
    check("reset resp_tag", 64'(resp_tag), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle req_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 17; i++) begin
      run32(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), res, rtag, lat);
      check($sformatf("vec%0d result", i), 64'(res), 64'(vecs[i].exp));
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(EO ? vecs[i].lat_eo : vecs[i].lat));
      check($sformatf("vec%0d tag", i), 64'(rtag), 64'(i + 1));
    end

    // Flush five cycles into CALC: no response may ever appear
    req_valid = 1'b1; req_op = OP_MUL; req_rs1 = 32'hFFFFFFFF; req_rs2 = 32'hFFFFFFFF;
    req_tag = 5'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("flush pre busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush resp_valid", 64'(resp_valid), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    check("flush no response", 64'(seen), 64'd0);

    // Flush wins over a simultaneous request
    flush = 1'b1; req_valid = 1'b1; req_op = OP_DIVU; req_rs1 = 32'd9; req_rs2 = 32'd3;
    #1;
    check("flush req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    check("flush req not accepted", 64'(busy), 64'd0);

    // Backpressure: response held for ten cycles, pending request blocked
    req_valid = 1'b1; req_op = OP_MUL; req_rs1 = 32'd3; req_rs2 = 32'd4; req_tag = 5'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("bp resp_valid", 64'(resp_valid), 64'd1);
    req_valid = 1'b1; req_op = OP_DIVU; req_rs1 = 32'd50; req_rs2 = 32'd5; req_tag = 5'd2;
    stable_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (resp_result !== 32'd12 || resp_tag !== 5'd9 || req_ready !== 1'b0 || resp_valid !== 1'b1)
        stable_ok = 1'b0;
    end
    check("bp hold stable", 64'(stable_ok), 64'd1);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
    check("bp req_ready after consume", 64'(req_ready), 64'd1);
    check("bp no accept on consume edge", 64'(busy), 64'd0);
    run32(OP_DIVU, 32'd100, 32'd7, 5'd21, res, rtag, lat);
    check("b2b result", 64'(res), 64'd14);
    check("b2b tag", 64'(rtag), 64'd21);

    // Asynchronous reset in the middle of a divide
    req_valid = 1'b1; req_op = OP_DIVU; req_rs1 = 32'd200; req_rs2 = 32'd3; req_tag = 5'd17;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    #2;
    reset = 1'b1;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset resp_valid", 64'(resp_valid), 64'd0);
    check("midreset resp_tag", 64'(resp_tag), 64'd0);
    check("midreset resp_result", 64'(resp_result), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    check("midreset no response", 64'(seen), 64'd0);

    // Wide, unrolled instance
    run64(OP_DIVU, 64'hFFFFFFFFFFFFFFFF, 64'd3, 5'd6, res64, rtag, lat);
    check("x64 divu result", res64, 64'h5555555555555555);
    check("x64 divu latency", 64'(lat), 64'd17);
    check("x64 divu tag", 64'(rtag), 64'd6);
    run64(OP_MUL, 64'd5, 64'd1, 5'd12, res64, rtag, lat);
    check("x64 mul result", res64, 64'd5);
    check("x64 mul latency", 64'(lat), EO ? 64'd2 : 64'd17);
    run64(OP_REM, 64'hFFFFFFFFFFFFFFF9, 64'd2, 5'd13, res64, rtag, lat);
    check("x64 rem result", res64, 64'hFFFFFFFFFFFFFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
